// File: rtl/cas_pkg.sv
// Shared definitions for the cassette stream player: mode encoding, fetch FSM
// states and default FSK/PCM timing in CPU Q-clock ticks.
package cas_pkg;

  localparam logic CAS_MODE_FSK = 1'b0;
  localparam logic CAS_MODE_PCM = 1'b1;

  localparam int unsigned CAS_HALF0     = 372;
  localparam int unsigned CAS_HALF1     = 186;
  localparam int unsigned CAS_PCM_TICKS = 81;

  typedef enum logic [1:0] {
    FetchIdle,
    FetchReq,
    FetchDrop
  } fetch_state_e;

endpackage

// File: rtl/cas_fifo.sv
// Byte-wide prefetch FIFO with first-word-fall-through read and a synchronous
// flush that empties it in one cycle.
module cas_fifo #(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       rd,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};

  logic [7:0]       mem_q [Depth];
  logic [FIFO_AW:0] wptr_q, wptr_d;
  logic [FIFO_AW:0] rptr_q, rptr_d;
  logic             wr_en, rd_en;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                 (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;
  assign dout  = mem_q[rptr_q[FIFO_AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_en) wptr_d = wptr_q + PtrOne;
      if (rd_en) rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) mem_q[wptr_q[FIFO_AW-1:0]] <= din;
  end

endmodule

// File: rtl/cas_stream_player.sv
// Cassette playback engine: prefetches tape bytes from image memory and plays
// them out as CoCo FSK or raw 8-bit PCM, paced by the CPU Q-clock enable.
module cas_stream_player
  import cas_pkg::*;
#(
  parameter int unsigned AW        = 16,
  parameter int unsigned FIFO_AW   = 2,
  parameter int unsigned HALF0     = CAS_HALF0,
  parameter int unsigned HALF1     = CAS_HALF1,
  parameter int unsigned PCM_TICKS = CAS_PCM_TICKS,
  parameter int unsigned CW        = 10
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          q_tick,
  input  logic          en,
  input  logic          rewind,
  input  logic          mode,
  input  logic [AW:0]   tape_len,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic          mem_ack,
  input  logic [7:0]    mem_data,
  output logic          data,
  output logic [7:0]    sample,
  output logic          eot,
  output logic          underrun,
  output logic [AW:0]   pos
);

  localparam logic [AW:0]   PosOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] TickOne = {{(CW-1){1'b0}}, 1'b1};

  fetch_state_e state_q, state_d;
  logic [AW:0]  addr_q, addr_d;
  logic [AW:0]  len_q, len_d;
  logic [AW:0]  pos_q, pos_d;
  logic [CW-1:0] tick_q, tick_d;
  logic [7:0]   shreg_q, shreg_d;
  logic [2:0]   bit_q, bit_d;
  logic         low_q, low_d;
  logic         active_q, active_d;
  logic         pcm_q, pcm_d;
  logic         data_q, data_d;
  logic [7:0]   sample_q, sample_d;
  logic         eot_q, eot_d;
  logic         underrun_q, underrun_d;

  logic         fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [7:0]   fifo_dout;
  logic [CW-1:0] limit;
  logic         tick_end, byte_end;

  cas_fifo #(
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RESET_N),
    .flush(rewind),
    .wr   (fifo_wr),
    .din  (mem_data),
    .rd   (fifo_rd),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign mem_rd   = (state_q != FetchIdle);
  assign mem_addr = addr_q[AW-1:0];
  assign data     = data_q;
  assign sample   = sample_q;
  assign eot      = eot_q;
  assign underrun = underrun_q;
  assign pos      = pos_q;

  // Fetch FSM: an ack always returns to idle, so requests never chain back to back.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    fifo_wr = 1'b0;
    if (rewind) addr_d = '0;
    unique case (state_q)
      FetchIdle: begin
        if (!rewind && !fifo_full && (addr_q < len_q)) state_d = FetchReq;
      end
      FetchReq: begin
        if (rewind) begin
          state_d = mem_ack ? FetchIdle : FetchDrop;
        end else if (mem_ack) begin
          fifo_wr = 1'b1;
          addr_d  = addr_q + PosOne;
          state_d = FetchIdle;
        end
      end
      FetchDrop: begin
        if (mem_ack) state_d = FetchIdle;
      end
      default: state_d = FetchIdle;
    endcase
  end

  // Half-cycle length follows the bit being sent; PCM uses one fixed sample period.
  assign limit    = pcm_q ? CW'(PCM_TICKS) : (shreg_q[0] ? CW'(HALF1) : CW'(HALF0));
  assign tick_end = (tick_q == limit - TickOne);
  assign byte_end = pcm_q || (low_q && (bit_q == 3'd7));

  always_comb begin
    len_d      = len_q;
    pos_d      = pos_q;
    tick_d     = tick_q;
    shreg_d    = shreg_q;
    bit_d      = bit_q;
    low_d      = low_q;
    active_d   = active_q;
    pcm_d      = pcm_q;
    data_d     = data_q;
    sample_d   = sample_q;
    eot_d      = eot_q;
    underrun_d = underrun_q;
    fifo_rd    = 1'b0;
    if (rewind) begin
      len_d      = tape_len;
      pos_d      = '0;
      tick_d     = '0;
      shreg_d    = '0;
      bit_d      = '0;
      low_d      = 1'b0;
      active_d   = 1'b0;
      pcm_d      = 1'b0;
      data_d     = 1'b0;
      sample_d   = '0;
      eot_d      = 1'b0;
      underrun_d = 1'b0;
    end else if (q_tick && en && !eot_q) begin
      if (active_q && !tick_end) begin
        tick_d = tick_q + TickOne;
      end else if (active_q && !byte_end) begin
        tick_d = '0;
        if (!low_q) begin
          low_d  = 1'b1;
          data_d = 1'b0;
        end else begin
          low_d   = 1'b0;
          bit_d   = bit_q + 3'd1;
          shreg_d = {1'b0, shreg_q[7:1]};
          data_d  = 1'b1;
        end
      end else if (pos_q >= len_q) begin
        eot_d    = 1'b1;
        data_d   = 1'b0;
        active_d = 1'b0;
      end else if (fifo_empty) begin
        // Stall without advancing; the next tick retries the pop.
        underrun_d = 1'b1;
        data_d     = 1'b0;
        active_d   = 1'b0;
      end else begin
        fifo_rd  = 1'b1;
        pos_d    = pos_q + PosOne;
        shreg_d  = fifo_dout;
        bit_d    = '0;
        low_d    = 1'b0;
        tick_d   = '0;
        active_d = 1'b1;
        pcm_d    = (mode == CAS_MODE_PCM);
        if (mode == CAS_MODE_PCM) begin
          sample_d = fifo_dout;
          data_d   = fifo_dout[7];
        end else begin
          data_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= FetchIdle;
      addr_q     <= '0;
      len_q      <= '0;
      pos_q      <= '0;
      tick_q     <= '0;
      shreg_q    <= '0;
      bit_q      <= '0;
      low_q      <= 1'b0;
      active_q   <= 1'b0;
      pcm_q      <= 1'b0;
      data_q     <= 1'b0;
      sample_q   <= '0;
      eot_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      pos_q      <= pos_d;
      tick_q     <= tick_d;
      shreg_q    <= shreg_d;
      bit_q      <= bit_d;
      low_q      <= low_d;
      active_q   <= active_d;
      pcm_q      <= pcm_d;
      data_q     <= data_d;
      sample_q   <= sample_d;
      eot_q      <= eot_d;
      underrun_q <= underrun_d;
    end
  end

endmodule

// File: tb/tb_cas_stream_player.sv
// Directed bench for cas_stream_player: FSK and PCM timing, prefetch while paused,
// rewind during a fetch, underrun recovery and asynchronous reset mid-playback.
module tb_cas_stream_player;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        q_tick = 1'b0;
  logic        en = 1'b0;
  logic        rewind = 1'b0;
  logic        mode = 1'b0;
  logic [16:0] tape_len = '0;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = '0;
  logic        data;
  logic [7:0]  sample;
  logic        eot;
  logic        underrun;
  logic [16:0] pos;

  int checks = 0;
  int errors = 0;
  int tick_n = 0;

  logic [7:0]  img [16];
  int          lat = 0;
  int          wait_cnt = 0;
  int          fetch_cnt = 0;
  logic [15:0] last_addr = '0;

  cas_stream_player dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .q_tick  (q_tick),
    .en      (en),
    .rewind  (rewind),
    .mode    (mode),
    .tape_len(tape_len),
    .mem_addr(mem_addr),
    .mem_rd  (mem_rd),
    .mem_ack (mem_ack),
    .mem_data(mem_data),
    .data    (data),
    .sample  (sample),
    .eot     (eot),
    .underrun(underrun),
    .pos     (pos)
  );

  always #5 CLK = ~CLK;

  // Image memory: acks a request after 'lat' extra cycles of mem_rd.
  always @(negedge CLK) begin
    if (mem_ack) begin
      mem_ack = 1'b0;
    end else if (mem_rd) begin
      if (wait_cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_data  = img[mem_addr[3:0]];
        last_addr = mem_addr;
        fetch_cnt = fetch_cnt + 1;
        wait_cnt  = 0;
      end else begin
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  task automatic one_tick();
    @(negedge CLK) q_tick = 1'b1;
    @(negedge CLK) q_tick = 1'b0;
    repeat (2) @(negedge CLK);
    tick_n = tick_n + 1;
  endtask

  task automatic tick_to(input int target);
    while (tick_n < target) one_tick();
  endtask

  task automatic rewind_pulse(input logic [16:0] len);
    @(negedge CLK);
    rewind   = 1'b1;
    tape_len = len;
    repeat (3) @(negedge CLK);
    rewind = 1'b0;
    tick_n = 0;
  endtask

  task automatic wait_fetches(input int target, input int bound, input string name);
    int n;
    n = 0;
    while (fetch_cnt < target && n < bound) begin
      @(posedge CLK);
      n++;
    end
    checks++;
    if (fetch_cnt < target) begin
      errors++;
      $display("FAIL %s: fetch count %0d, required %0d", name, fetch_cnt, target);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++;
    if ({data, sample, eot, underrun, pos, mem_rd, mem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%b sample=%h eot=%b und=%b pos=%0d rd=%b addr=%h, required all 0",
               data, sample, eot, underrun, pos, mem_rd, mem_addr);
    end
    RESET_N = 1'b1;
  endtask

  task automatic test_fsk();
    int base;
    en = 1'b0; mode = 1'b0; lat = 0;
    img[0] = 8'h01;
    base = fetch_cnt;
    rewind_pulse(17'd1);
    wait_fetches(base + 1, 50, "fsk_fetch");
    en = 1'b1;
    tick_to(1);
    checks++;
    if (data !== 1'b1 || pos !== 17'd1) begin
      errors++;
      $display("FAIL fsk_start: data=%b pos=%0d, required 1/1", data, pos);
    end
    tick_to(186);
    checks++;
    if (data !== 1'b1) begin errors++; $display("FAIL fsk_t186: data=%b, required 1", data); end
    tick_to(187);
    checks++;
    if (data !== 1'b0) begin errors++; $display("FAIL fsk_t187: data=%b, required 0", data); end
    tick_to(372);
    checks++;
    if (data !== 1'b0) begin errors++; $display("FAIL fsk_t372: data=%b, required 0", data); end
    tick_to(373);
    checks++;
    if (data !== 1'b1) begin errors++; $display("FAIL fsk_t373: data=%b, required 1", data); end
    tick_to(744);
    checks++;
    if (data !== 1'b1) begin errors++; $display("FAIL fsk_t744: data=%b, required 1", data); end
    tick_to(745);
    checks++;
    if (data !== 1'b0) begin errors++; $display("FAIL fsk_t745: data=%b, required 0", data); end
    tick_to(1117);
    checks++;
    if (data !== 1'b1) begin errors++; $display("FAIL fsk_t1117: data=%b, required 1", data); end
    tick_to(5580);
    checks++;
    if (data !== 1'b0 || eot !== 1'b0) begin
      errors++;
      $display("FAIL fsk_t5580: data=%b eot=%b, required 0/0", data, eot);
    end
    tick_to(5581);
    checks++;
    if (eot !== 1'b1 || data !== 1'b0 || pos !== 17'd1) begin
      errors++;
      $display("FAIL fsk_eot: eot=%b data=%b pos=%0d, required 1/0/1", eot, data, pos);
    end
  endtask

  task automatic test_pcm_latency();
    int base;
    en = 1'b0; mode = 1'b1; lat = 10;
    img[0] = 8'h80; img[1] = 8'h7F;
    base = fetch_cnt;
    rewind_pulse(17'd2);
    checks++;
    if (eot !== 1'b0) begin errors++; $display("FAIL pcm_eot_cleared: eot=%b, required 0", eot); end
    wait_fetches(base + 2, 100, "pcm_fetch");
    en = 1'b1;
    tick_to(1);
    checks++;
    if (sample !== 8'h80 || data !== 1'b1 || pos !== 17'd1) begin
      errors++;
      $display("FAIL pcm_first: sample=%h data=%b pos=%0d, required 80/1/1", sample, data, pos);
    end
    tick_to(81);
    checks++;
    if (sample !== 8'h80) begin errors++; $display("FAIL pcm_t81: sample=%h, required 80", sample); end
    tick_to(82);
    checks++;
    if (sample !== 8'h7F || data !== 1'b0 || pos !== 17'd2) begin
      errors++;
      $display("FAIL pcm_second: sample=%h data=%b pos=%0d, required 7f/0/2", sample, data, pos);
    end
    tick_to(162);
    checks++;
    if (eot !== 1'b0) begin errors++; $display("FAIL pcm_t162: eot=%b, required 0", eot); end
    tick_to(163);
    checks++;
    if (eot !== 1'b1 || data !== 1'b0) begin
      errors++;
      $display("FAIL pcm_eot: eot=%b data=%b, required 1/0", eot, data);
    end
  endtask

  task automatic test_pause_prefetch();
    int base;
    en = 1'b0; mode = 1'b1; lat = 0;
    for (int i = 0; i < 8; i++) img[i] = 8'hC3 + 8'(i);
    base = fetch_cnt;
    rewind_pulse(17'd8);
    repeat (60) @(negedge CLK);
    checks++;
    if (fetch_cnt - base !== 4 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL pause_fill: fetches=%0d rd=%b, required 4/0", fetch_cnt - base, mem_rd);
    end
    repeat (3) one_tick();
    checks++;
    if (pos !== 17'd0 || data !== 1'b0) begin
      errors++;
      $display("FAIL pause_frozen: pos=%0d data=%b, required 0/0", pos, data);
    end
    en = 1'b1;
    one_tick();
    checks++;
    if (pos !== 17'd1 || sample !== 8'hC3 || data !== 1'b1) begin
      errors++;
      $display("FAIL pause_start: pos=%0d sample=%h data=%b, required 1/c3/1", pos, sample, data);
    end
    en = 1'b0;
    repeat (20) @(negedge CLK);
    checks++;
    if (fetch_cnt - base !== 5) begin
      errors++;
      $display("FAIL pause_refill: fetches=%0d, required 5", fetch_cnt - base);
    end
    repeat (100) one_tick();
    checks++;
    if (pos !== 17'd1 || data !== 1'b1 || sample !== 8'hC3) begin
      errors++;
      $display("FAIL pause_hold: pos=%0d data=%b sample=%h, required 1/1/c3", pos, data, sample);
    end
  endtask

  task automatic test_rewind_req();
    int base, n;
    en = 1'b0; mode = 1'b1; lat = 0;
    for (int i = 0; i < 8; i++) img[i] = 8'h10 + 8'(i);
    base = fetch_cnt;
    rewind_pulse(17'd8);
    wait_fetches(base + 4, 40, "rw_fill");
    repeat (4) @(negedge CLK);
    lat = 5;
    en  = 1'b1;
    one_tick();
    en = 1'b0;
    n = 0;
    while (mem_rd !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    checks++;
    if (mem_rd !== 1'b1 || mem_addr !== 16'd4) begin
      errors++;
      $display("FAIL rw_req: rd=%b addr=%0d, required 1/4", mem_rd, mem_addr);
    end
    base = fetch_cnt;
    rewind   = 1'b1;
    tape_len = 17'd8;
    repeat (2) @(negedge CLK);
    checks++;
    if (mem_rd !== 1'b1) begin errors++; $display("FAIL rw_drop_hold: rd=%b, required 1", mem_rd); end
    repeat (12) @(negedge CLK);
    checks++;
    if (fetch_cnt - base !== 1 || mem_rd !== 1'b0 || pos !== 17'd0 || data !== 1'b0) begin
      errors++;
      $display("FAIL rw_drop_done: acks=%0d rd=%b pos=%0d data=%b, required 1/0/0/0",
               fetch_cnt - base, mem_rd, pos, data);
    end
    lat = 0;
    base = fetch_cnt;
    rewind = 1'b0;
    tick_n = 0;
    wait_fetches(base + 1, 20, "rw_refetch");
    #1;
    checks++;
    if (last_addr !== 16'd0) begin
      errors++;
      $display("FAIL rw_first_addr: addr=%0d, required 0", last_addr);
    end
    repeat (10) @(negedge CLK);
    en = 1'b1;
    one_tick();
    checks++;
    if (sample !== 8'h10 || pos !== 17'd1) begin
      errors++;
      $display("FAIL rw_first_byte: sample=%h pos=%0d, required 10/1", sample, pos);
    end
  endtask

  task automatic test_underrun();
    int base;
    en = 1'b0; mode = 1'b1; lat = 400;
    img[0] = 8'h90; img[1] = 8'h41;
    base = fetch_cnt;
    rewind_pulse(17'd2);
    wait_fetches(base + 1, 500, "und_fetch");
    en = 1'b1;
    tick_to(1);
    checks++;
    if (sample !== 8'h90 || data !== 1'b1 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL und_first: sample=%h data=%b und=%b, required 90/1/0", sample, data, underrun);
    end
    tick_to(82);
    checks++;
    if (underrun !== 1'b1 || data !== 1'b0 || pos !== 17'd1) begin
      errors++;
      $display("FAIL und_stall: und=%b data=%b pos=%0d, required 1/0/1", underrun, data, pos);
    end
    tick_to(95);
    checks++;
    if (underrun !== 1'b1 || pos !== 17'd1 || data !== 1'b0) begin
      errors++;
      $display("FAIL und_still: und=%b pos=%0d data=%b, required 1/1/0", underrun, pos, data);
    end
    tick_to(110);
    checks++;
    if (pos !== 17'd2 || sample !== 8'h41 || underrun !== 1'b1) begin
      errors++;
      $display("FAIL und_resume: pos=%0d sample=%h und=%b, required 2/41/1", pos, sample, underrun);
    end
    tick_to(200);
    checks++;
    if (eot !== 1'b1) begin errors++; $display("FAIL und_eot: eot=%b, required 1", eot); end
    lat = 0;
    rewind_pulse(17'd2);
    checks++;
    if (underrun !== 1'b0 || eot !== 1'b0) begin
      errors++;
      $display("FAIL und_clear: und=%b eot=%b, required 0/0", underrun, eot);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    en = 1'b0; mode = 1'b1; lat = 0;
    img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3; img[3] = 8'hD4;
    base = fetch_cnt;
    rewind_pulse(17'd4);
    wait_fetches(base + 4, 40, "rst_fill");
    en = 1'b1;
    tick_to(100);
    checks++;
    if (pos !== 17'd2 || sample !== 8'hB2) begin
      errors++;
      $display("FAIL rst_pre: pos=%0d sample=%h, required 2/b2", pos, sample);
    end
    @(posedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({data, sample, eot, underrun, pos, mem_rd, mem_addr} !== '0) begin
      errors++;
      $display("FAIL rst_async: data=%b sample=%h eot=%b und=%b pos=%0d rd=%b addr=%h, required all 0",
               data, sample, eot, underrun, pos, mem_rd, mem_addr);
    end
    @(negedge CLK) RESET_N = 1'b1;
    one_tick();
    checks++;
    if (eot !== 1'b1 || data !== 1'b0) begin
      errors++;
      $display("FAIL rst_len0: eot=%b data=%b, required 1/0", eot, data);
    end
    en = 1'b0;
    base = fetch_cnt;
    rewind_pulse(17'd4);
    wait_fetches(base + 4, 40, "rst_refill");
    en = 1'b1;
    one_tick();
    checks++;
    if (sample !== 8'hA1 || pos !== 17'd1 || eot !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: sample=%h pos=%0d eot=%b, required a1/1/0", sample, pos, eot);
    end
  endtask

  initial begin
    test_reset();
    test_fsk();
    test_pcm_latency();
    test_pause_prefetch();
    test_rewind_req();
    test_underrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
